// File: rtl/dmem_arb_pkg.sv
// Shared types for the dual-issue data-memory arbiter.
package dmem_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  // FSM: IDLE serves live lanes; SERVE_B replays the buffered lane-B access.
  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    SERVE_B = 1'b1
  } state_e;

  // One lane's memory request at the default widths.
  typedef struct packed {
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } dmem_req_t;

endpackage

// File: rtl/dmem_dual_issue_arbiter.sv
// Single-port data memory arbiter for the two MEM-stage issue lanes.
// Lane A (older) goes first; a dual access stalls one cycle and lane B is
// replayed from a buffer, with both load results presented on release.
// Optional macro DMEM_STORE_FWD_EN: same-address A-store/B-load and
// A-load/B-load pairs complete in one cycle without a stall.
// Handshake: there is no valid/ready; a lane request is accepted when
// mem_stall is low at the clock edge, and the pipeline holds both lanes
// steady while mem_stall is high.
module dmem_dual_issue_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = dmem_arb_pkg::ADDR_W,
  parameter int DATA_W = dmem_arb_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_mem_read,
  input  logic              a_mem_write,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic              b_mem_read,
  input  logic              b_mem_write,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] a_rdata,
  output logic [DATA_W-1:0] b_rdata,
  output logic              mem_stall,
  output state_e            dbg_state
);

  state_e            state;
  logic              buf_rd;
  logic              buf_wr;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_wdata;
  logic [DATA_W-1:0] a_rdata_q;

  // A lane with both read and write high behaves as a store.
  logic a_rd_eff, b_rd_eff, a_act, b_act, conflict, fwd_st, fwd_ld, stall_req;

  assign a_rd_eff = a_mem_read & ~a_mem_write;
  assign b_rd_eff = b_mem_read & ~b_mem_write;
  assign a_act    = a_mem_read | a_mem_write;
  assign b_act    = b_mem_read | b_mem_write;
  assign conflict = a_act & b_act;

`ifdef DMEM_STORE_FWD_EN
  logic same_addr;
  assign same_addr = (a_addr == b_addr);
  assign fwd_st    = same_addr & a_mem_write & b_rd_eff;
  assign fwd_ld    = same_addr & a_rd_eff & b_rd_eff;
`else
  assign fwd_st = 1'b0;
  assign fwd_ld = 1'b0;
`endif

  assign stall_req = conflict & ~fwd_st & ~fwd_ld;
  assign dbg_state = state;

  // FSM plus lane-B buffer and held lane-A load result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      buf_rd    <= 1'b0;
      buf_wr    <= 1'b0;
      buf_addr  <= '0;
      buf_wdata <= '0;
      a_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (stall_req) begin
            a_rdata_q <= a_rd_eff ? mem_rdata : '0;
            buf_rd    <= b_rd_eff;
            buf_wr    <= b_mem_write;
            buf_addr  <= b_addr;
            buf_wdata <= b_wdata;
            state     <= SERVE_B;
          end
        end
        SERVE_B: begin
          buf_rd <= 1'b0;
          buf_wr <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory bus and lane results; everything reads zero while reset is low.
  always_comb begin
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    a_rdata   = '0;
    b_rdata   = '0;
    mem_stall = 1'b0;
    if (!rst_n) begin
      mem_re = 1'b0;
    end else if (state == SERVE_B) begin
      mem_re    = buf_rd;
      mem_we    = buf_wr;
      mem_addr  = buf_addr;
      mem_wdata = buf_wdata;
      a_rdata   = a_rdata_q;
      b_rdata   = buf_rd ? mem_rdata : '0;
    end else if (a_act) begin
      mem_re    = a_rd_eff;
      mem_we    = a_mem_write;
      mem_addr  = a_addr;
      mem_wdata = a_wdata;
      a_rdata   = a_rd_eff ? mem_rdata : '0;
      if (fwd_st) begin
        b_rdata = a_wdata;
      end else if (fwd_ld) begin
        b_rdata = mem_rdata;
      end
      mem_stall = stall_req;
    end else if (b_act) begin
      mem_re    = b_rd_eff;
      mem_we    = b_mem_write;
      mem_addr  = b_addr;
      mem_wdata = b_wdata;
      b_rdata   = b_rd_eff ? mem_rdata : '0;
    end
  end

  // A lane must never request a load and a store together.
  a_rd_wr_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(a_mem_read && a_mem_write));
  b_rd_wr_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(b_mem_read && b_mem_write));

endmodule

// File: tb/tb_dmem_dual_issue_arbiter.sv
// Directed bench for dmem_dual_issue_arbiter with a word-addressed memory model.
module tb_dmem_dual_issue_arbiter;
  import dmem_arb_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        a_mem_read, a_mem_write, b_mem_read, b_mem_write;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        mem_re, mem_we, mem_stall;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, a_rdata, b_rdata;
  state_e      dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  // Memory model: combinational read, write on rising edge, plus preload port.
  logic [31:0] mem_arr [0:255];
  logic        pre_we;
  logic [7:0]  pre_idx;
  logic [31:0] pre_val;

  assign mem_rdata = mem_arr[mem_addr[9:2]];

  always @(posedge clk) begin
    if (pre_we) mem_arr[pre_idx] <= pre_val;
    else if (mem_we) mem_arr[mem_addr[9:2]] <= mem_wdata;
  end

  dmem_dual_issue_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_mem_read(a_mem_read), .a_mem_write(a_mem_write), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_mem_read(b_mem_read), .b_mem_write(b_mem_write), .b_addr(b_addr), .b_wdata(b_wdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .a_rdata(a_rdata), .b_rdata(b_rdata),
    .mem_stall(mem_stall), .dbg_state(dbg_state)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       name;
    logic        a_rd, a_wr;
    logic [31:0] a_ad, a_wd;
    logic        b_rd, b_wr;
    logic [31:0] b_ad, b_wd;
    logic        e_re, e_we;
    logic [31:0] e_addr, e_wdata, e_a, e_b;
    logic        e_stall;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic e_re, input logic e_we,
                            input logic [31:0] e_addr, input logic [31:0] e_wdata,
                            input logic [31:0] e_a, input logic [31:0] e_b,
                            input logic e_stall);
    check({tag, ".re"},    32'(mem_re),    32'(e_re));
    check({tag, ".we"},    32'(mem_we),    32'(e_we));
    check({tag, ".addr"},  mem_addr,       e_addr);
    check({tag, ".wdata"}, mem_wdata,      e_wdata);
    check({tag, ".a"},     a_rdata,        e_a);
    check({tag, ".b"},     b_rdata,        e_b);
    check({tag, ".stall"}, 32'(mem_stall), 32'(e_stall));
  endtask

  task automatic drive(input logic ar, input logic aw, input logic [31:0] aa, input logic [31:0] ad,
                       input logic br, input logic bw, input logic [31:0] ba, input logic [31:0] bd);
    a_mem_read = ar; a_mem_write = aw; a_addr = aa; a_wdata = ad;
    b_mem_read = br; b_mem_write = bw; b_addr = ba; b_wdata = bd;
  endtask

  task automatic drive_idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic preload(input logic [31:0] addr, input logic [31:0] val);
    @(negedge clk);
    pre_we = 1'b1; pre_idx = addr[9:2]; pre_val = val;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  // Starts at posedge+1: drive, check at negedge, advance to next posedge+1.
  task automatic apply_vec(input vec_t v);
    drive(v.a_rd, v.a_wr, v.a_ad, v.a_wd, v.b_rd, v.b_wr, v.b_ad, v.b_wd);
    @(negedge clk);
    check_outs(v.name, v.e_re, v.e_we, v.e_addr, v.e_wdata, v.e_a, v.e_b, v.e_stall);
    @(posedge clk);
    #1;
  endtask

  initial begin
    //                name        a_rd a_wr a_ad   a_wd          b_rd b_wr b_ad   b_wd   re we addr   wdata         a_rdata       b_rdata       stall
    vecs[0] = '{"a_load",   1, 0, 32'h10, 32'h0,        0, 0, 32'h0,  32'h0,  1, 0, 32'h10, 32'h0,        32'hDEADBEEF, 32'h0,        0};
    vecs[1] = '{"b_store",  0, 0, 32'h0,  32'h0,        0, 1, 32'h40, 32'h55, 0, 1, 32'h40, 32'h55,       32'h0,        32'h0,        0};
    vecs[2] = '{"b_load",   0, 0, 32'h0,  32'h0,        1, 0, 32'h40, 32'h0,  1, 0, 32'h40, 32'h0,        32'h0,        32'h55,       0};
    vecs[3] = '{"a_store",  0, 1, 32'h10, 32'h11111111, 0, 0, 32'h0,  32'h0,  0, 1, 32'h10, 32'h11111111, 32'h0,        32'h0,        0};
    vecs[4] = '{"a_reload", 1, 0, 32'h10, 32'h0,        0, 0, 32'h0,  32'h0,  1, 0, 32'h10, 32'h0,        32'h11111111, 32'h0,        0};
    vecs[5] = '{"idle",     0, 0, 32'h0,  32'h0,        0, 0, 32'h0,  32'h0,  0, 0, 32'h0,  32'h0,        32'h0,        32'h0,        0};
    vecs[6] = '{"b_load14", 0, 0, 32'h0,  32'h0,        1, 0, 32'h14, 32'h0,  1, 0, 32'h14, 32'h0,        32'h0,        32'h22222222, 0};
    vecs[7] = '{"a_st44",   0, 1, 32'h44, 32'hA5A5A5A5, 0, 0, 32'h0,  32'h0,  0, 1, 32'h44, 32'hA5A5A5A5, 32'h0,        32'h0,        0};
    vecs[8] = '{"a_ld44",   1, 0, 32'h44, 32'h0,        0, 0, 32'h0,  32'h0,  1, 0, 32'h44, 32'h0,        32'hA5A5A5A5, 32'h0,        0};

    // Reset and preload
    rst_n = 1'b0;
    pre_we = 1'b0; pre_idx = 8'h0; pre_val = 32'h0;
    drive_idle();
    for (int i = 0; i < 256; i++) mem_arr[i] = 32'h0;
    preload(32'h10, 32'hDEADBEEF);
    preload(32'h14, 32'h22222222);
    preload(32'h50, 32'h00000077);
    @(negedge clk);
    check_outs("reset", 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0);
    check("reset.state", 32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven single-lane vectors
    for (int i = 0; i < 9; i++) apply_vec(vecs[i]);

    // Dual load: 0x10 holds 0x11111111, 0x14 holds 0x22222222
    drive(1, 0, 32'h10, 32'h0, 1, 0, 32'h14, 32'h0);
    @(negedge clk);
    check_outs("dual_ld.c0", 1, 0, 32'h10, 32'h0, 32'h11111111, 32'h0, 1);
    @(posedge clk);
    #1;
    check("dual_ld.state", 32'(dbg_state), 32'(SERVE_B));
    @(negedge clk);
    check_outs("dual_ld.c1", 1, 0, 32'h14, 32'h0, 32'h11111111, 32'h22222222, 0);
    @(posedge clk);
    #1 drive_idle();

    // A store then B load, same address
    drive(0, 1, 32'h20, 32'hCAFEF00D, 1, 0, 32'h20, 32'h0);
    @(negedge clk);
`ifdef DMEM_STORE_FWD_EN
    check_outs("st_ld.c0", 0, 1, 32'h20, 32'hCAFEF00D, 32'h0, 32'hCAFEF00D, 0);
    @(posedge clk);
    #1 drive_idle();
`else
    check_outs("st_ld.c0", 0, 1, 32'h20, 32'hCAFEF00D, 32'h0, 32'h0, 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_outs("st_ld.c1", 1, 0, 32'h20, 32'h0, 32'h0, 32'hCAFEF00D, 0);
    @(posedge clk);
    #1 drive_idle();
`endif

    // Two stores, same address: B wins
    drive(0, 1, 32'h30, 32'h1, 0, 1, 32'h30, 32'h2);
    @(negedge clk);
    check_outs("st_st.c0", 0, 1, 32'h30, 32'h1, 32'h0, 32'h0, 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_outs("st_st.c1", 0, 1, 32'h30, 32'h2, 32'h0, 32'h0, 0);
    @(posedge clk);
    #1 drive_idle();
    apply_vec('{"st_st.rd", 1, 0, 32'h30, 32'h0, 0, 0, 32'h0, 32'h0,
                1, 0, 32'h30, 32'h0, 32'h2, 32'h0, 0});

    // Reset asserted while serving lane B
    drive(0, 1, 32'h48, 32'h9, 0, 1, 32'h50, 32'hAA);
    @(negedge clk);
    check_outs("rst_mid.c0", 0, 1, 32'h48, 32'h9, 32'h0, 32'h0, 1);
    @(posedge clk);
    #1;
    check_outs("rst_mid.c1", 0, 1, 32'h50, 32'hAA, 32'h0, 32'h0, 0);
    rst_n = 1'b0;
    #1;
    check_outs("rst_mid.async", 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0);
    check("rst_mid.state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    drive_idle();
    @(posedge clk);
    #1;
    check("rst_mid.mem_b", mem_arr[8'h14], 32'h00000077);
    check("rst_mid.mem_a", mem_arr[8'h12], 32'h00000009);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid.state_rel", 32'(dbg_state), 32'(IDLE));
    apply_vec('{"rst_mid.rd", 0, 0, 32'h0, 32'h0, 1, 0, 32'h50, 32'h0,
                1, 0, 32'h50, 32'h0, 32'h0, 32'h77, 0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_dual_issue_arbiter.md
Name: dmem_dual_issue_arbiter

Overview:
Shares the single-port data memory between the two MEM-stage issue lanes of the dual-issue pipeline. Lane A is the older instruction in program order; lane B is the younger. When both lanes access memory in the same cycle, the block serializes them A-then-B. It raises a one-cycle pipeline stall and returns both lanes' load data together on the release cycle. Memory read is combinational; memory write commits on the clk rising edge.

Parameters:
ADDR_W, 32, byte address width of ALU-result address
DATA_W, 32, data word width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
a_mem_read  in  1  lane A load request
a_mem_write  in  1  lane A store request
a_addr  in  ADDR_W  lane A address
a_wdata  in  DATA_W  lane A store data
b_mem_read  in  1  lane B load request
b_mem_write  in  1  lane B store request
b_addr  in  ADDR_W  lane B address
b_wdata  in  DATA_W  lane B store data
mem_re  out  1  read enable to data memory
mem_we  out  1  write enable to data memory
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  combinational read data from memory
a_rdata  out  DATA_W  lane A load result
b_rdata  out  DATA_W  lane B load result
mem_stall  out  1  freeze IF..MEM and hold EX/MEM register

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Lane request rules:
  - A lane is active when its read or write input is high.
  - Read and write both high on one lane is illegal; the lane is treated as a write and the condition is flagged by the assertion below.
- States: IDLE, SERVE_B.
- Reset: state=IDLE, b buffer cleared, a_rdata_q=0. Outputs: mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0, a_rdata=0, b_rdata=0, mem_stall=0.
- IDLE, zero or one lane active:
  - Drive memory combinationally from the active lane.
  - That lane's rdata = mem_rdata if it is a read, else 0.
  - Other lane rdata=0; mem_stall=0.
- IDLE, both lanes active (conflict):
  - Drive memory from lane A; mem_stall=1.
  - On clk: latch A load data into a_rdata_q (0 if A is a store). Latch lane B request fields into the buffer. Go to SERVE_B.
- SERVE_B:
  - Drive memory from the buffered B request, not from the live inputs.
  - mem_stall=0; a_rdata=a_rdata_q; b_rdata=mem_rdata if B is a read, else 0.
  - On clk: go to IDLE.
  - Live inputs are ignored in this cycle; the pipeline holds them, and they advance on this edge.
- Latency: no added latency without a conflict. With a conflict, exactly one stall cycle, and both results are valid in the release cycle.
- Ordering:
  - A store then B load, same address: B reads the committed value (write lands at the end of cycle 0).
  - A load then B store, same address: A sees the old value.
  - Two stores to the same address: B's value wins.
- Address comparison uses full ADDR_W with no masking.
- Reset asserted in SERVE_B: B access is aborted, the buffer is dropped, and the block goes to IDLE; no partial write is issued after reset.
- The idle memory bus drives zeros (mem_addr=0, mem_wdata=0) so no spurious writes occur.

Optional Feature:
DMEM_STORE_FWD_EN
- Defined: conflict bypass when a_addr==b_addr and no stall is needed.
  - A store + B load: memory performs A's write; b_rdata=a_wdata in the same cycle; mem_stall=0.
  - A load + B load: one read; both lanes get mem_rdata; mem_stall=0.
  - All other same-address or different-address conflicts serialize as normal.
- Undefined: every dual access serializes through SERVE_B.

Decomposition:
- Package dmem_arb_pkg holds:
  - the state enum {IDLE, SERVE_B};
  - a request struct {rd, wr, addr, wdata};
  - default width constants ADDR_W=32, DATA_W=32.
- No sub-module: the B buffer and FSM are small enough to stay inline.
- An assertion block checks that rd and wr are never both high on the same lane.

Test Plan:
- Single lane: A load, addr 0x10 holding 0xDEADBEEF, B idle → a_rdata=0xDEADBEEF same cycle, b_rdata=0, mem_stall=0.
- Dual load: A load 0x10 (0x11111111), B load 0x14 (0x22222222) → cycle 0 stall=1, mem_addr=0x10; cycle 1 stall=0, mem_addr=0x14, a_rdata=0x11111111, b_rdata=0x22222222.
- Store→load same address: A stores 0xCAFEF00D @0x20, B loads 0x20 → stall=1 for 1 cycle, then b_rdata=0xCAFEF00D. With DMEM_STORE_FWD_EN: no stall, b_rdata=0xCAFEF00D in cycle 0.
- Double store: A stores 0x1 @0x30, B stores 0x2 @0x30 → 2 write cycles; a later load of 0x30 returns 0x2.
- Reset mid-op: dual store conflict, rst_n low in SERVE_B → B write is not performed, mem @B addr unchanged; all outputs return to 0 immediately (asynchronously); state=IDLE after release.
- Lane B only: B store 0x55 @0x40 → mem_we=1, mem_addr=0x40, mem_stall=0, a_rdata=0.
